// File: rtl/clk_sel_controller.sv
// clk_sel_controller: drives the select of a downstream glitch-free clock mux.
// When a different clock is requested, the controller first proves that the
// target clock is alive. It then flips sel, waits for the mux to settle, and
// holds for a dwell period before it accepts another request.
//
// Build option: define CLK_SEL_LIVENESS_CHECK_EN to include the CHECK state
// and the tog synchronizers. When it is undefined, IDLE goes straight to
// SETTLE and err_dead is tied low.
//
// Request protocol: req_sel is a level, not a valid/ready handshake. The
// controller samples it only in IDLE, and in CHECK for aborts. busy = 1 means
// changes to req_sel are ignored until the controller returns to IDLE.
module clk_sel_controller #(
    parameter bit RESET_SEL     = 1'b0,
    parameter int ALIVE_EDGES   = 4,
    parameter int ALIVE_TIMEOUT = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int DWELL_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_sel,
    input  logic       clk0_tog,
    input  logic       clk1_tog,
    output logic       sel,
    output logic       busy,
    output logic       switch_done,
    output logic       err_dead,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int MAX_A = (ALIVE_EDGES > ALIVE_TIMEOUT) ? ALIVE_EDGES : ALIVE_TIMEOUT;
    localparam int MAX_B = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] C_DWELL  = CW'(DWELL_CYCLES);

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    state_t        r_state;
    logic          r_sel;
    logic          r_busy;
    logic          r_switch_done;
    logic [CW-1:0] r_cyc_cnt;
    logic [CW-1:0] w_cyc_nx;

    assign w_cyc_nx = sat_inc(r_cyc_cnt);

`ifdef CLK_SEL_LIVENESS_CHECK_EN
    localparam logic [CW-1:0] C_EDGES   = CW'(ALIVE_EDGES);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(ALIVE_TIMEOUT);

    logic          r_t0_s1, r_t0_s2, r_t0_h;
    logic          r_t1_s1, r_t1_s2, r_t1_h;
    logic          r_err_dead;
    logic [CW-1:0] r_edge_cnt;
    logic          w_tgt_edge;
    logic [CW-1:0] w_edge_nx;

    // Two-flop synchronizers plus a history flop for edge detection on each tog.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_t0_s1 <= 1'b0; r_t0_s2 <= 1'b0; r_t0_h <= 1'b0;
            r_t1_s1 <= 1'b0; r_t1_s2 <= 1'b0; r_t1_h <= 1'b0;
        end else begin
            r_t0_s1 <= clk0_tog; r_t0_s2 <= r_t0_s1; r_t0_h <= r_t0_s2;
            r_t1_s1 <= clk1_tog; r_t1_s2 <= r_t1_s1; r_t1_h <= r_t1_s2;
        end
    end

    assign w_tgt_edge = req_sel ? (r_t1_s2 ^ r_t1_h) : (r_t0_s2 ^ r_t0_h);
    assign w_edge_nx  = w_tgt_edge ? sat_inc(r_edge_cnt) : r_edge_cnt;
    assign err_dead   = r_err_dead;
`else
    logic w_unused_tog;
    assign w_unused_tog = clk0_tog ^ clk1_tog;
    assign err_dead     = 1'b0;
`endif

    // Main FSM. All outputs are registered and updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= RESET_SEL;
            r_busy        <= 1'b0;
            r_switch_done <= 1'b0;
            r_cyc_cnt     <= '0;
`ifdef CLK_SEL_LIVENESS_CHECK_EN
            r_err_dead    <= 1'b0;
            r_edge_cnt    <= '0;
`endif
        end else begin
            r_switch_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_sel == r_sel) begin
`ifdef CLK_SEL_LIVENESS_CHECK_EN
                        r_err_dead <= 1'b0;
`endif
                    end
`ifdef CLK_SEL_LIVENESS_CHECK_EN
                    else if (!r_err_dead) begin
                        r_state    <= ST_CHECK;
                        r_busy     <= 1'b1;
                        r_cyc_cnt  <= '0;
                        r_edge_cnt <= '0;
                    end
`else
                    else begin
                        r_state   <= ST_SETTLE;
                        r_sel     <= req_sel;
                        r_busy    <= 1'b1;
                        r_cyc_cnt <= '0;
                    end
`endif
                end
`ifdef CLK_SEL_LIVENESS_CHECK_EN
                ST_CHECK: begin
                    r_edge_cnt <= w_edge_nx;
                    r_cyc_cnt  <= w_cyc_nx;
                    if (req_sel == r_sel) begin
                        // Request withdrawn: leave quietly, no error.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_edge_nx >= C_EDGES) begin
                        // Enough edges wins even on the timeout cycle.
                        r_state   <= ST_SETTLE;
                        r_sel     <= req_sel;
                        r_cyc_cnt <= '0;
                    end else if (w_cyc_nx >= C_TIMEOUT) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_err_dead <= 1'b1;
                    end
                end
`endif
                ST_SETTLE: begin
                    r_cyc_cnt <= w_cyc_nx;
                    if (w_cyc_nx >= C_SETTLE) begin
                        r_state       <= ST_HOLD;
                        r_switch_done <= 1'b1;
                        r_cyc_cnt     <= '0;
`ifdef CLK_SEL_LIVENESS_CHECK_EN
                        r_err_dead    <= 1'b0;
`endif
                    end
                end
                ST_HOLD: begin
                    r_cyc_cnt <= w_cyc_nx;
                    if (w_cyc_nx >= C_DWELL) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel         = r_sel;
    assign busy        = r_busy;
    assign switch_done = r_switch_done;
    assign dbg_state   = r_state;

endmodule

// File: doc/clk_sel_controller.md
CLK_SEL_CONTROLLER -- requirements
Module: clk_sel_controller

Interface
- REQ-001 Parameter RESET_SEL, default 0: value driven on sel while reset is active and after reset.
- REQ-002 Parameter ALIVE_EDGES, default 4: target-clock toggle edges required before switching.
- REQ-003 Parameter ALIVE_TIMEOUT, default 64: clk cycles allowed for ALIVE_EDGES edges to arrive.
- REQ-004 Parameter SETTLE_CYCLES, default 8: clk cycles held in SETTLE after sel changes.
- REQ-005 Parameter DWELL_CYCLES, default 16: minimum clk cycles in HOLD before a new request is accepted.
- REQ-006 clk  input  1  always-on controller clock; sole clock of this block.
- REQ-007 reset  input  1  synchronous, active-high reset.
- REQ-008 req_sel  input  1  requested clock source (level): 0 = clk_0, 1 = clk_1.
- REQ-009 clk0_tog  input  1  toggle signal generated in the clk_0 domain; asynchronous to clk.
- REQ-010 clk1_tog  input  1  toggle signal generated in the clk_1 domain; asynchronous to clk.
- REQ-011 sel  output  1  registered select driven to the downstream glitch-free clock mux.
- REQ-012 busy  output  1  high in every state except IDLE.
- REQ-013 switch_done  output  1  single-cycle pulse when a switch completes settling.
- REQ-014 err_dead  output  1  sticky flag: target clock showed no activity within ALIVE_TIMEOUT.

Function
- REQ-015 Each tog input SHALL pass through a 2-flop synchronizer plus one history flop; edge = sync2 XOR history.
- REQ-016 The FSM SHALL have states IDLE, CHECK, SETTLE and HOLD, with IDLE as the reset state.
- REQ-017 IDLE: if req_sel != sel and err_dead = 0 in cycle N, the FSM SHALL enter CHECK in cycle N+1, clearing both counters.
- REQ-018 CHECK: the block SHALL count edges only on the target tog (clk1_tog if req_sel = 1, else clk0_tog), plus elapsed cycles.
- REQ-019 CHECK: on the cycle the edge count reaches ALIVE_EDGES, the FSM SHALL enter SETTLE, and sel SHALL take the target value on that same transition.
- REQ-020 CHECK: if ALIVE_TIMEOUT cycles elapse first, the FSM SHALL return to IDLE, set err_dead = 1 and leave sel unchanged.
- REQ-021 CHECK: if req_sel changes to equal sel, the FSM SHALL abort to IDLE on the next cycle without an error.
- REQ-022 If the edge count reaches ALIVE_EDGES on the same cycle as the timeout, the switch SHALL take priority.
- REQ-023 SETTLE: after SETTLE_CYCLES cycles the FSM SHALL enter HOLD, and switch_done SHALL pulse for exactly that transition cycle.
- REQ-024 HOLD: after DWELL_CYCLES cycles the FSM SHALL return to IDLE; req_sel SHALL be ignored during SETTLE and HOLD and re-evaluated in IDLE.
- REQ-025 err_dead SHALL clear when, in IDLE, req_sel == sel, and on any completed switch; it SHALL block retries while set.
- REQ-026 Counters SHALL be sized to $clog2(max parameter + 1) bits and SHALL saturate rather than wrap.
- REQ-027 sel SHALL change at most once per request, and never in IDLE, CHECK or HOLD.

Reset
- REQ-028 While reset = 1 at a clk edge: state = IDLE, sel = RESET_SEL, busy = 0, switch_done = 0, err_dead = 0, counters and synchronizers = 0.
- REQ-029 Reset asserted mid-CHECK, SETTLE or HOLD SHALL abandon the operation and force sel back to RESET_SEL on the next edge.

Configuration
- REQ-030 Macro CLK_SEL_LIVENESS_CHECK_EN defined: CHECK state and tog synchronizers are present, as specified above.
- REQ-031 Macro CLK_SEL_LIVENESS_CHECK_EN undefined: IDLE goes directly to SETTLE (sel updated on that transition), CHECK and synchronizers are removed, err_dead is tied to 0, and tog inputs are unused.

Verification (defaults; macro defined unless noted)
- REQ-032 Reset, then req_sel 0->1 with clk1_tog toggling every 3 clk cycles: sel = 1 after 4 synced edges; switch_done pulses 8 cycles later; busy is low 16 cycles after that.
- REQ-033 req_sel = 1 with clk1_tog static: after 64 cycles in CHECK, err_dead = 1, sel = 0 and no retry occurs; then req_sel = 0 -> err_dead clears.
- REQ-034 req_sel pulsed 1 for 5 cycles during CHECK with clk1_tog static: abort to IDLE, sel = 0, err_dead = 0.
- REQ-035 Toggle req_sel during SETTLE and HOLD: sel unchanged until HOLD completes; the new request is honoured from IDLE.
- REQ-036 Assert reset for 1 cycle mid-SETTLE with RESET_SEL = 0: next cycle sel = 0, busy = 0, switch_done never pulses.
- REQ-037 Macro undefined, req_sel 0->1: sel = 1 one cycle after IDLE sees the request; err_dead stays 0.
